decode_mod_rm_collector: RTL and testbench
==========================================

Name: decode_mod_rm_collector

Overview:
Sequential front-end stage directly upstream of the combinational ModR/M decoder. Once opcode decode flags that an instruction carries a ModR/M byte, this block consumes the following bytes from the byte stream: ModR/M, optional SIB, and 0/1/2/4 displacement bytes. It applies 386 addressing-size rules and emits one aligned packet per instruction to the ModR/M decoder and the address stage.

Parameters:
SIGN_EXTEND_DISP, 1, 1: sign-extend disp8/disp16 to 32 bits; 0: zero-extend.

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high reset
start_valid  input  1  opcode stage requests a ModR/M collection
start_ready  output  1  block idle, start accepted
start_addr_32  input  1  effective address size for this instruction; 1 = 32-bit, 0 = 16-bit
byte_valid  input  1  byte_data valid
byte_data  input  8  next instruction byte
byte_ready  output  1  block consumes byte_data this cycle
out_valid  output  1  packet valid
out_ready  input  1  consumer accepts packet
out_mod_rm  output  8  collected ModR/M byte
out_sib  output  8  collected SIB byte; 0 if absent
out_sib_present  output  1  SIB byte was collected
out_displacement  output  32  assembled displacement (little-endian), extended per parameter
out_disp_len  output  3  displacement bytes: 0, 1, 2 or 4
out_length  output  3  total bytes consumed: 1 to 6
out_addr_32  output  1  latched start_addr_32

Behaviour:
- Reset (synchronous, active-high, dominates all other inputs): state=IDLE. All out_* = 0. start_ready=1, byte_ready=0, out_valid=0. Reset mid-operation discards partial bytes and latched state.
- States: IDLE, MODRM, SIB, DISP, DONE.
- IDLE: start_ready=1. On start_valid, latch start_addr_32, clear the output registers, go to MODRM.
- MODRM/SIB/DISP: byte_ready=1, start_ready=0. A byte is consumed only when byte_valid && byte_ready. With byte_valid=0 the block holds state and no register changes.
- MODRM (byte consumed): latch out_mod_rm. Decode mod=[7:6], rm=[2:0].
  - 16-bit: mod=11 → len 0. mod=00, rm=110 → len 2. Other mod=00 → len 0. mod=01 → len 1. mod=10 → len 2. No SIB.
  - 32-bit: mod≠11 and rm=100 → SIB. Otherwise: mod=00, rm=101 → len 4. Other mod=00 → len 0. mod=01 → len 1. mod=10 → len 4. mod=11 → len 0.
  - Next state is SIB, DISP (len>0), or DONE.
- SIB (byte consumed): latch out_sib, set out_sib_present=1. Length is 1 for mod=01, 4 for mod=10, and 4 for mod=00 when SIB base=101; otherwise 0. Go to DISP or DONE.
- DISP: byte k (0-based) is written to out_displacement[8k+7:8k]. A byte counter advances per consumed byte. After byte len-1, apply the extension (bits 31:8 for len 1, bits 31:16 for len 2) and go to DONE. The extended value is visible on the same edge that enters DONE.
- out_length = 1 + out_sib_present + out_disp_len, stable in DONE.
- DONE: out_valid=1. All outputs are held stable until out_ready. On out_valid && out_ready, go to IDLE and drop out_valid on the next cycle.
- Latency with no stalls: start in cycle 0, last byte in cycle N, out_valid in cycle N+1.
- Minimum spacing between starts is one idle cycle after packet acceptance; start_ready=0 in DONE.
- start_valid outside IDLE is ignored. byte_data is never consumed in IDLE or DONE.

Test Plan:
- 32-bit, bytes 44 F3 20 → out_mod_rm=44, out_sib=F3, out_sib_present=1, out_displacement=00000020, out_disp_len=1, out_length=3.
- 16-bit, bytes 40 06 → mod_rm=40, out_sib_present=0, out_displacement=00000006, out_disp_len=1, out_length=2. Then bytes 06 34 12 → displacement=00001234, out_disp_len=2, out_length=3.
- 32-bit, bytes 04 25 78 56 34 12 (SIB base=101, mod=00) → out_displacement=12345678, out_disp_len=4, out_length=6. Also, 16-bit disp8 byte 80 with SIGN_EXTEND_DISP=1 → FFFFFF80; with SIGN_EXTEND_DISP=0 → 00000080.
- Byte C0 in either mode → out_length=1, out_disp_len=0, out_displacement=0. out_valid rises the cycle after the byte.
- Back-pressure: byte_valid toggled 1/0 mid-displacement and out_ready held low 5 cycles → no byte lost or duplicated, outputs stable for all 5 cycles, start_ready=0 throughout.
- Reset asserted one cycle after the SIB byte is consumed → next cycle state=IDLE, out_valid=0, start_ready=1. A subsequent 16-bit start with byte C0 yields out_length=1 with out_sib=0.

Source files
------------

// File: rtl/decode_mod_rm_collector.sv
// ModR/M byte collector.
// Sits between opcode decode and the combinational ModR/M decoder. After a
// start request it consumes the ModR/M byte, an optional SIB byte and 0/1/2/4
// displacement bytes. It then presents one aligned packet that is held until
// the consumer accepts it.
module decode_mod_rm_collector #(
  parameter bit SIGN_EXTEND_DISP = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start_valid,
  output logic        start_ready,
  input  logic        start_addr_32,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_mod_rm,
  output logic [7:0]  out_sib,
  output logic        out_sib_present,
  output logic [31:0] out_displacement,
  output logic [2:0]  out_disp_len,
  output logic [2:0]  out_length,
  output logic        out_addr_32
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_MODRM = 3'd1,
    ST_SIB   = 3'd2,
    ST_DISP  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  mod_rm_q, mod_rm_d;
  logic [7:0]  sib_q, sib_d;
  logic        sib_present_q, sib_present_d;
  logic [31:0] disp_q, disp_d;
  logic [2:0]  disp_len_q, disp_len_d;
  logic [2:0]  length_q, length_d;
  logic        addr_32_q, addr_32_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        start_ready_q, start_ready_d;
  logic        byte_ready_q, byte_ready_d;
  logic        out_valid_q, out_valid_d;
  logic        byte_fire_s;

  // A SIB byte follows in 32-bit mode for any memory form with rm=100.
  function automatic logic modrm_has_sib(input logic addr_32, input logic [7:0] modrm);
    logic r;
    r = addr_32 && (modrm[7:6] != 2'b11) && (modrm[2:0] == 3'b100);
    return r;
  endfunction

  // Displacement length implied by a ModR/M byte that is not followed by SIB.
  function automatic logic [2:0] modrm_disp_len(input logic addr_32, input logic [7:0] modrm);
    logic [2:0] len;
    case (modrm[7:6])
      2'b00: begin
        if (addr_32) begin
          len = (modrm[2:0] == 3'b101) ? 3'd4 : 3'd0;
        end else begin
          len = (modrm[2:0] == 3'b110) ? 3'd2 : 3'd0;
        end
      end
      2'b01:   len = 3'd1;
      2'b10:   len = addr_32 ? 3'd4 : 3'd2;
      2'b11:   len = 3'd0;
      default: len = 3'd0;
    endcase
    return len;
  endfunction

  // Displacement length once a SIB byte is known (32-bit addressing only).
  function automatic logic [2:0] sib_disp_len(input logic [1:0] md, input logic [2:0] base);
    logic [2:0] len;
    case (md)
      2'b00:   len = (base == 3'b101) ? 3'd4 : 3'd0;
      2'b01:   len = 3'd1;
      2'b10:   len = 3'd4;
      default: len = 3'd0;
    endcase
    return len;
  endfunction

  // Widen a completed disp8/disp16 to 32 bits; disp32 passes unchanged.
  function automatic logic [31:0] extend_disp(input logic [31:0] raw, input logic [2:0] len);
    logic [31:0] r;
    case (len)
      3'd1:    r = {(SIGN_EXTEND_DISP ? {24{raw[7]}} : 24'd0), raw[7:0]};
      3'd2:    r = {(SIGN_EXTEND_DISP ? {16{raw[15]}} : 16'd0), raw[15:0]};
      default: r = raw;
    endcase
    return r;
  endfunction

  assign byte_fire_s = byte_valid && byte_ready_q;

  // Next-state and datapath computation for the collection sequence.
  always_comb begin
    state_d       = state_q;
    mod_rm_d      = mod_rm_q;
    sib_d         = sib_q;
    sib_present_d = sib_present_q;
    disp_d        = disp_q;
    disp_len_d    = disp_len_q;
    length_d      = length_q;
    addr_32_d     = addr_32_q;
    cnt_d         = cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (start_valid) begin
          addr_32_d     = start_addr_32;
          mod_rm_d      = 8'd0;
          sib_d         = 8'd0;
          sib_present_d = 1'b0;
          disp_d        = 32'd0;
          disp_len_d    = 3'd0;
          length_d      = 3'd0;
          cnt_d         = 2'd0;
          state_d       = ST_MODRM;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_MODRM: begin
        if (byte_fire_s) begin
          mod_rm_d = byte_data;
          if (modrm_has_sib(addr_32_q, byte_data)) begin
            state_d = ST_SIB;
          end else begin
            disp_len_d = modrm_disp_len(addr_32_q, byte_data);
            if (disp_len_d != 3'd0) begin
              state_d = ST_DISP;
            end else begin
              state_d = ST_DONE;
            end
          end
        end else begin
          state_d = ST_MODRM;
        end
      end

      ST_SIB: begin
        if (byte_fire_s) begin
          sib_d         = byte_data;
          sib_present_d = 1'b1;
          disp_len_d    = sib_disp_len(mod_rm_q[7:6], byte_data[2:0]);
          if (disp_len_d != 3'd0) begin
            state_d = ST_DISP;
          end else begin
            state_d = ST_DONE;
          end
        end else begin
          state_d = ST_SIB;
        end
      end

      ST_DISP: begin
        if (byte_fire_s) begin
          disp_d[{cnt_q, 3'b000} +: 8] = byte_data;
          cnt_d = cnt_q + 2'd1;
          if ({1'b0, cnt_q} == (disp_len_q - 3'd1)) begin
            disp_d  = extend_disp(disp_d, disp_len_q);
            state_d = ST_DONE;
          end else begin
            state_d = ST_DISP;
          end
        end else begin
          state_d = ST_DISP;
        end
      end

      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Total length is fixed on the edge that enters DONE.
    if ((state_d == ST_DONE) && (state_q != ST_DONE)) begin
      length_d = 3'd1 + {2'b00, sib_present_d} + disp_len_d;
    end else begin
      length_d = length_d;
    end
  end

  // Handshake outputs are registered copies of the next state's role.
  always_comb begin
    start_ready_d = (state_d == ST_IDLE);
    byte_ready_d  = (state_d == ST_MODRM) || (state_d == ST_SIB) || (state_d == ST_DISP);
    out_valid_d   = (state_d == ST_DONE);
  end

  // State and output registers; reset discards any partial packet.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      mod_rm_q      <= 8'd0;
      sib_q         <= 8'd0;
      sib_present_q <= 1'b0;
      disp_q        <= 32'd0;
      disp_len_q    <= 3'd0;
      length_q      <= 3'd0;
      addr_32_q     <= 1'b0;
      cnt_q         <= 2'd0;
      start_ready_q <= 1'b1;
      byte_ready_q  <= 1'b0;
      out_valid_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      mod_rm_q      <= mod_rm_d;
      sib_q         <= sib_d;
      sib_present_q <= sib_present_d;
      disp_q        <= disp_d;
      disp_len_q    <= disp_len_d;
      length_q      <= length_d;
      addr_32_q     <= addr_32_d;
      cnt_q         <= cnt_d;
      start_ready_q <= start_ready_d;
      byte_ready_q  <= byte_ready_d;
      out_valid_q   <= out_valid_d;
    end
  end

  assign start_ready      = start_ready_q;
  assign byte_ready       = byte_ready_q;
  assign out_valid        = out_valid_q;
  assign out_mod_rm       = mod_rm_q;
  assign out_sib          = sib_q;
  assign out_sib_present  = sib_present_q;
  assign out_displacement = disp_q;
  assign out_disp_len     = disp_len_q;
  assign out_length       = length_q;
  assign out_addr_32      = addr_32_q;

endmodule

// File: tb/tb_decode_mod_rm_collector.sv
// Testbench for decode_mod_rm_collector. Two instances share the same stimulus:
// one sign-extends displacements and one zero-extends them. Directed vectors
// come from a table. Random packets are checked against a rule-level model.
module tb_decode_mod_rm_collector;

  logic        clock = 1'b0;
  logic        reset;
  logic        start_valid, start_addr_32, byte_valid, out_ready;
  logic [7:0]  byte_data;

  logic        start_ready, byte_ready, out_valid, out_sib_present, out_addr_32;
  logic [7:0]  out_mod_rm, out_sib;
  logic [31:0] out_displacement;
  logic [2:0]  out_disp_len, out_length;

  logic        zx_start_ready, zx_byte_ready, zx_out_valid, zx_sib_present, zx_addr_32;
  logic [7:0]  zx_mod_rm, zx_sib;
  logic [31:0] zx_displacement;
  logic [2:0]  zx_disp_len, zx_length;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  decode_mod_rm_collector #(.SIGN_EXTEND_DISP(1'b1)) u_sx (
    .clock(clock), .reset(reset),
    .start_valid(start_valid), .start_ready(start_ready), .start_addr_32(start_addr_32),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_mod_rm(out_mod_rm), .out_sib(out_sib), .out_sib_present(out_sib_present),
    .out_displacement(out_displacement), .out_disp_len(out_disp_len),
    .out_length(out_length), .out_addr_32(out_addr_32)
  );

  decode_mod_rm_collector #(.SIGN_EXTEND_DISP(1'b0)) u_zx (
    .clock(clock), .reset(reset),
    .start_valid(start_valid), .start_ready(zx_start_ready), .start_addr_32(start_addr_32),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(zx_byte_ready),
    .out_valid(zx_out_valid), .out_ready(out_ready),
    .out_mod_rm(zx_mod_rm), .out_sib(zx_sib), .out_sib_present(zx_sib_present),
    .out_displacement(zx_displacement), .out_disp_len(zx_disp_len),
    .out_length(zx_length), .out_addr_32(zx_addr_32)
  );

  typedef struct {
    logic [7:0]  mod_rm;
    logic [7:0]  sib;
    logic        sp;
    logic [31:0] dsx;
    logic [31:0] dzx;
    logic [2:0]  dl;
    logic [2:0]  len;
  } pkt_t;

  typedef struct {
    bit          a32;
    logic [47:0] b;   // byte k at b[8k+7:8k]
    pkt_t        e;
  } vec_t;

  vec_t vt[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [47:0] pk(input logic [7:0] b0, input logic [7:0] b1,
                                     input logic [7:0] b2, input logic [7:0] b3,
                                     input logic [7:0] b4, input logic [7:0] b5);
    return {b5, b4, b3, b2, b1, b0};
  endfunction

  function automatic vec_t mkv(input bit a32, input logic [47:0] b, input logic [7:0] sib,
                               input logic sp, input logic [31:0] dsx, input logic [31:0] dzx,
                               input logic [2:0] dl, input logic [2:0] len);
    vec_t v;
    v.a32 = a32; v.b = b;
    v.e.mod_rm = b[7:0]; v.e.sib = sib; v.e.sp = sp;
    v.e.dsx = dsx; v.e.dzx = dzx; v.e.dl = dl; v.e.len = len;
    return v;
  endfunction

  // Reference: packet contents derived from the x86 addressing rules using integer arithmetic.
  function automatic pkt_t model(input bit a32, input logic [47:0] b);
    pkt_t p;
    int md, rm, base, dl, sp;
    longint v, vs;
    md = int'(b[7:6]);
    rm = int'(b[2:0]);
    sp = (a32 && md != 3 && rm == 4) ? 1 : 0;
    if (!a32) dl = (md == 3) ? 0 : (md == 1) ? 1 : (md == 2) ? 2 : (rm == 6) ? 2 : 0;
    else if (sp == 1) begin
      base = int'(b[10:8]);
      dl = (md == 1) ? 1 : (md == 2) ? 4 : (base == 5) ? 4 : 0;
    end
    else dl = (md == 3) ? 0 : (md == 1) ? 1 : (md == 2) ? 4 : (rm == 5) ? 4 : 0;
    v = 0;
    for (int k = 0; k < dl; k++) v = v + (longint'(b[(1 + sp + k) * 8 +: 8]) << (8 * k));
    vs = v;
    if (dl > 0 && dl < 4 && v >= (longint'(1) << (8 * dl - 1))) vs = v - (longint'(1) << (8 * dl));
    p.mod_rm = b[7:0];
    p.sib    = (sp == 1) ? b[15:8] : 8'h00;
    p.sp     = (sp == 1);
    p.dzx    = v[31:0];
    p.dsx    = vs[31:0];
    p.dl     = 3'(dl);
    p.len    = 3'(1 + sp + dl);
    return p;
  endfunction

  task automatic check_pkt(input string tag, input bit a32, input pkt_t e);
    chk({tag, ".valid"},   32'(out_valid),        32'd1);
    chk({tag, ".mod_rm"},  32'(out_mod_rm),       32'(e.mod_rm));
    chk({tag, ".sib"},     32'(out_sib),          32'(e.sib));
    chk({tag, ".sib_p"},   32'(out_sib_present),  32'(e.sp));
    chk({tag, ".disp_sx"}, out_displacement,      e.dsx);
    chk({tag, ".disp_zx"}, zx_displacement,       e.dzx);
    chk({tag, ".disp_len"},32'(out_disp_len),     32'(e.dl));
    chk({tag, ".length"},  32'(out_length),       32'(e.len));
    chk({tag, ".len_zx"},  32'(zx_length),        32'(e.len));
    chk({tag, ".addr32"},  32'(out_addr_32),      32'(a32));
    chk({tag, ".start_rdy"}, 32'(start_ready),    32'd0);
  endtask

  // Drive one packet: start, feed bytes (with optional stalls), hold, accept.
  task automatic run_pkt(input string tag, input bit a32, input logic [47:0] b, input pkt_t e,
                         input int stall_pct, input int hold);
    int waitc, idx, cyc;
    bit got;
    waitc = 0;
    while (!start_ready && waitc < 50) begin
      @(negedge clock);
      waitc++;
    end
    chk({tag, ".start_wait"}, 32'(start_ready), 32'd1);
    start_valid = 1'b1; start_addr_32 = a32; byte_valid = 1'b0;
    @(negedge clock);
    start_valid = 1'b0;
    idx = 0; got = 1'b0; cyc = 1;
    while (!got && cyc < 300) begin
      if (out_valid) got = 1'b1;
      else begin
        if (byte_ready && idx < 6 && int'($urandom_range(99)) >= stall_pct) begin
          byte_valid = 1'b1;
          byte_data  = b[idx * 8 +: 8];
          idx++;
        end else begin
          byte_valid = 1'b0;
          byte_data  = 8'($urandom);
        end
        @(negedge clock);
        cyc++;
      end
    end
    chk({tag, ".got_valid"}, 32'(got), 32'd1);
    chk({tag, ".consumed"}, 32'(idx), 32'(e.len));
    if (stall_pct == 0) chk({tag, ".latency"}, 32'(cyc), 32'(e.len) + 32'd1);
    check_pkt(tag, a32, e);
    for (int h = 0; h < hold; h++) begin
      out_ready   = 1'b0;
      start_valid = 1'b1;
      start_addr_32 = ~a32;
      byte_valid  = 1'b1;
      byte_data   = 8'($urandom);
      @(negedge clock);
      check_pkt({tag, ".hold"}, a32, e);
    end
    start_valid = 1'b0;
    byte_valid  = 1'b0;
    out_ready   = 1'b1;
    @(negedge clock);
    out_ready = 1'b0;
    chk({tag, ".drop_valid"}, 32'(out_valid), 32'd0);
    chk({tag, ".idle_rdy"},   32'(start_ready), 32'd1);
  endtask

  initial begin
    reset = 1'b1; start_valid = 1'b0; start_addr_32 = 1'b0;
    byte_valid = 1'b0; byte_data = 8'h00; out_ready = 1'b0;

    vt[0]  = mkv(1'b1, pk(8'h44, 8'hF3, 8'h20, 8'h00, 8'h00, 8'h00), 8'hF3, 1'b1, 32'h00000020, 32'h00000020, 3'd1, 3'd3);
    vt[1]  = mkv(1'b0, pk(8'h40, 8'h06, 8'h00, 8'h00, 8'h00, 8'h00), 8'h00, 1'b0, 32'h00000006, 32'h00000006, 3'd1, 3'd2);
    vt[2]  = mkv(1'b0, pk(8'h06, 8'h34, 8'h12, 8'h00, 8'h00, 8'h00), 8'h00, 1'b0, 32'h00001234, 32'h00001234, 3'd2, 3'd3);
    vt[3]  = mkv(1'b1, pk(8'h04, 8'h25, 8'h78, 8'h56, 8'h34, 8'h12), 8'h25, 1'b1, 32'h12345678, 32'h12345678, 3'd4, 3'd6);
    vt[4]  = mkv(1'b0, pk(8'h40, 8'h80, 8'h00, 8'h00, 8'h00, 8'h00), 8'h00, 1'b0, 32'hFFFFFF80, 32'h00000080, 3'd1, 3'd2);
    vt[5]  = mkv(1'b0, pk(8'hC0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00), 8'h00, 1'b0, 32'h00000000, 32'h00000000, 3'd0, 3'd1);
    vt[6]  = mkv(1'b1, pk(8'hC0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00), 8'h00, 1'b0, 32'h00000000, 32'h00000000, 3'd0, 3'd1);
    vt[7]  = mkv(1'b0, pk(8'h80, 8'h00, 8'h80, 8'h00, 8'h00, 8'h00), 8'h00, 1'b0, 32'hFFFF8000, 32'h00008000, 3'd2, 3'd3);
    vt[8]  = mkv(1'b1, pk(8'h05, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h00), 8'h00, 1'b0, 32'hDEADBEEF, 32'hDEADBEEF, 3'd4, 3'd5);
    vt[9]  = mkv(1'b1, pk(8'h84, 8'h24, 8'h01, 8'h02, 8'h03, 8'h04), 8'h24, 1'b1, 32'h04030201, 32'h04030201, 3'd4, 3'd6);
    vt[10] = mkv(1'b1, pk(8'h04, 8'h24, 8'h00, 8'h00, 8'h00, 8'h00), 8'h24, 1'b1, 32'h00000000, 32'h00000000, 3'd0, 3'd2);

    repeat (2) @(negedge clock);
    reset = 1'b0;
    chk("rst.start_ready", 32'(start_ready), 32'd1);
    chk("rst.byte_ready",  32'(byte_ready),  32'd0);
    chk("rst.out_valid",   32'(out_valid),   32'd0);
    chk("rst.length",      32'(out_length),  32'd0);
    chk("rst.mod_rm",      32'(out_mod_rm),  32'd0);
    chk("rst.disp",        out_displacement, 32'd0);

    // Directed vectors without stalls.
    for (int i = 0; i < 11; i++) begin
      @(negedge clock);
      run_pkt($sformatf("vec%0d", i), vt[i].a32, vt[i].b, vt[i].e, 0, 1);
    end

    // Back-pressure: stalls mid-displacement, consumer holds off 5 cycles.
    @(negedge clock);
    run_pkt("bp", vt[3].a32, vt[3].b, vt[3].e, 50, 5);

    // Reset one cycle after the SIB byte is consumed.
    @(negedge clock);
    start_valid = 1'b1; start_addr_32 = 1'b1;
    @(negedge clock);
    start_valid = 1'b0; byte_valid = 1'b1; byte_data = 8'h44;
    @(negedge clock);
    byte_data = 8'hF3;
    @(negedge clock);
    byte_valid = 1'b0;
    chk("midrst.in_disp", 32'(byte_ready), 32'd1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("midrst.out_valid",   32'(out_valid),   32'd0);
    chk("midrst.start_ready", 32'(start_ready), 32'd1);
    chk("midrst.byte_ready",  32'(byte_ready),  32'd0);
    chk("midrst.sib_p",       32'(out_sib_present), 32'd0);
    run_pkt("midrst.c0", vt[5].a32, vt[5].b, vt[5].e, 0, 0);

    // Random packets against the reference model.
    for (int r = 0; r < 300; r++) begin
      bit a32;
      logic [47:0] b;
      a32 = 1'($urandom);
      b   = {16'($urandom), 32'($urandom)};
      if (r % 2 == 0) b[7:0] = 8'($urandom) & 8'hC7 | 8'(3'($urandom_range(4, 5)));
      run_pkt($sformatf("rnd%0d", r), a32, b, model(a32, b), int'($urandom_range(60)), int'($urandom_range(3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
